// File: rtl/frame_stream_tx_if.sv
// frame_stream_tx_if: load port, start request and pixel stream of frame_stream_tx.
// master drives loads/start, slave is the frame source.
interface frame_stream_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data_0;
  logic [DATA_WIDTH-1:0] load_data_1;
  logic [DATA_WIDTH-1:0] load_data_2;
  logic                  start;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic [DATA_WIDTH-1:0] data_out_2;
  logic                  busy;
  logic                  done;
  logic                  load_err;

  modport master (
    output load_en, load_addr,
    output load_data_0, load_data_1, load_data_2,
    output start,
    input  valid_out,
    input  data_out_0, data_out_1, data_out_2,
    input  busy, done, load_err
  );

  modport slave (
    input  load_en, load_addr,
    input  load_data_0, load_data_1, load_data_2,
    input  start,
    output valid_out,
    output data_out_0, data_out_1, data_out_2,
    output busy, done, load_err
  );
endinterface

// File: rtl/frame_stream_tx.sv
// frame_stream_tx: buffered 3-channel raster frame source with trailing flush.
// FRAME_STREAM_TX_STALL_EN adds a stall_in input that pauses the stream.
module frame_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 224,
  parameter int HEIGHT     = 224,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic resetn,
`ifdef FRAME_STREAM_TX_STALL_EN
  input  logic stall_in,
`endif
  frame_stream_tx_if.slave bus
);
  localparam int PIX_N = WIDTH * HEIGHT;
  localparam int IW    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int FW    = $clog2(WIDTH + 2);
  localparam logic [ADDR_WIDTH:0]   PIX_LIM  = (ADDR_WIDTH+1)'(PIX_N);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(PIX_N - 1);
  localparam logic [FW-1:0]         FL_LAST  = FW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] pix, pix_n, pix_inc;
  logic [FW-1:0]         fl, fl_n;

  logic valid_q, valid_n;
  logic busy_q, busy_n;
  logic done_q, done_n;
  logic err_q, err_n;

  logic [DATA_WIDTH-1:0] d0_q, d1_q, d2_q;
  logic [DATA_WIDTH-1:0] d0_n, d1_n, d2_n;
  logic [DATA_WIDTH-1:0] rd0, rd1, rd2;

  logic          rd_en;
  logic [IW-1:0] rd_addr;
  logic          wr_en;
  logic          stall;

  logic [DATA_WIDTH-1:0] mem0 [PIX_N];
  logic [DATA_WIDTH-1:0] mem1 [PIX_N];
  logic [DATA_WIDTH-1:0] mem2 [PIX_N];

`ifdef FRAME_STREAM_TX_STALL_EN
  assign stall = stall_in;
`else
  assign stall = 1'b0;
`endif

  assign pix_inc = pix + ADDR_WIDTH'(1);

  assign wr_en = bus.load_en
              && (state == S_IDLE)
              && ({1'b0, bus.load_addr} < PIX_LIM);
  assign err_n = bus.load_en && !wr_en;

  // Buffers are not reset; reads happen from PRIME on, after any same-cycle load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem0[bus.load_addr[IW-1:0]] <= bus.load_data_0;
      mem1[bus.load_addr[IW-1:0]] <= bus.load_data_1;
      mem2[bus.load_addr[IW-1:0]] <= bus.load_data_2;
    end
    if (rd_en) begin
      rd0 <= mem0[rd_addr];
      rd1 <= mem1[rd_addr];
      rd2 <= mem2[rd_addr];
    end
  end

  always_comb begin
    state_n = state;
    pix_n   = pix;
    fl_n    = fl;
    valid_n = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    d0_n    = '0;
    d1_n    = '0;
    d2_n    = '0;
    rd_en   = 1'b0;
    rd_addr = pix_inc[IW-1:0];
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_PRIME;
          pix_n   = '0;
          fl_n    = '0;
          busy_n  = 1'b1;
        end
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_n = S_STREAM;
      end
      S_STREAM: begin
        if (stall) begin
          d0_n = d0_q;
          d1_n = d1_q;
          d2_n = d2_q;
        end else begin
          valid_n = 1'b1;
          d0_n    = rd0;
          d1_n    = rd1;
          d2_n    = rd2;
          rd_en   = (pix != PIX_LAST);
          if (pix == PIX_LAST) begin
            state_n = S_FLUSH;
          end else begin
            pix_n = pix_inc;
          end
        end
      end
      S_FLUSH: begin
        if (stall) begin
          d0_n = d0_q;
          d1_n = d1_q;
          d2_n = d2_q;
        end else begin
          valid_n = 1'b1;
          if (fl == FL_LAST) begin
            state_n = S_DONE;
          end else begin
            fl_n = fl + FW'(1);
          end
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pix     <= '0;
      fl      <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state   <= state_n;
      pix     <= pix_n;
      fl      <= fl_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      d0_q    <= d0_n;
      d1_q    <= d1_n;
      d2_q    <= d2_n;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.data_out_0 = d0_q;
  assign bus.data_out_1 = d1_q;
  assign bus.data_out_2 = d2_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_err   = err_q;
endmodule

// File: tb/tb_frame_stream_tx.sv
// tb_frame_stream_tx: directed bench for frame_stream_tx on a 4x3 frame.
// Stall steps are built only with FRAME_STREAM_TX_STALL_EN.
module tb_frame_stream_tx;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic resetn = 1'b0;
`ifdef FRAME_STREAM_TX_STALL_EN
  logic stall_in = 1'b0;
  int st_a = -1;
  int st_a_len = 0;
  int st_b = -1;
  int st_b_len = 0;
`endif

  frame_stream_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_stream_tx #(
    .DATA_WIDTH(DW),
    .WIDTH(W),
    .HEIGHT(H),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
`ifdef FRAME_STREAM_TX_STALL_EN
    .stall_in(stall_in),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m0 [N];
  logic [31:0] m1 [N];
  logic [31:0] m2 [N];
  logic [31:0] c0 [$];
  logic [31:0] c1 [$];
  logic [31:0] c2 [$];
  int nvalid, ndone, done_at, nbusy, nerr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] v0,
                      input logic [31:0] v1, input logic [31:0] v2);
    bus.load_en     = 1'b1;
    bus.load_addr   = AW'(a);
    bus.load_data_0 = v0;
    bus.load_data_1 = v1;
    bus.load_data_2 = v2;
    if (a < N) begin
      m0[a] = v0;
      m1[a] = v1;
      m2[a] = v2;
    end
    @(negedge clk);
    bus.load_en = 1'b0;
    check($sformatf("load_err_a%0d", a), bus.load_err, (a >= N) ? 1 : 0);
  endtask

  task automatic run_frame(input int start_at, input int load_at,
                           input int rst_at);
`ifdef FRAME_STREAM_TX_STALL_EN
    int cnt = 0;
`endif
    c0.delete();
    c1.delete();
    c2.delete();
    nvalid = 0;
    ndone = 0;
    done_at = 0;
    nbusy = 0;
    nerr = 0;
    bus.start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        c0.push_back(bus.data_out_0);
        c1.push_back(bus.data_out_1);
        c2.push_back(bus.data_out_2);
        nvalid++;
      end
      if (bus.done) begin
        ndone++;
        done_at = i;
      end
      if (bus.busy) nbusy++;
      if (bus.load_err) nerr++;
      bus.start = 1'b0;
      bus.load_en = 1'b0;
      if (bus.valid_out && nvalid - 1 == start_at) bus.start = 1'b1;
      if (bus.valid_out && nvalid - 1 == load_at) begin
        bus.load_en     = 1'b1;
        bus.load_addr   = AW'(2);
        bus.load_data_0 = 32'h0000_0BAD;
      end
`ifdef FRAME_STREAM_TX_STALL_EN
      if (bus.valid_out && nvalid - 1 == st_a) cnt = st_a_len;
      if (bus.valid_out && nvalid - 1 == st_b) cnt = st_b_len;
      stall_in = (cnt > 0);
      if (cnt > 0) cnt--;
`endif
      if (bus.valid_out && nvalid - 1 == rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_async_valid", bus.valid_out, 0);
        check("rst_async_busy", bus.busy, 0);
        @(negedge clk);
        resetn = 1'b1;
      end
      if (ndone > 0 && i > done_at + 1) break;
    end
    bus.start = 1'b0;
    bus.load_en = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_done);
    logic [31:0] o0, o1, o2;
    check({tag, "_nvalid"}, nvalid, N + W + 1);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_done_at"}, done_at, exp_done);
    check({tag, "_busy_cycles"}, nbusy, exp_done - 1);
    for (int k = 0; k < N + W + 1; k++) begin
      o0 = (k < nvalid) ? c0[k] : 32'hxxxx_xxxx;
      o1 = (k < nvalid) ? c1[k] : 32'hxxxx_xxxx;
      o2 = (k < nvalid) ? c2[k] : 32'hxxxx_xxxx;
      check($sformatf("%s_w%0d_ch0", tag, k), o0, (k < N) ? m0[k] : 0);
      check($sformatf("%s_w%0d_ch1", tag, k), o1, (k < N) ? m1[k] : 0);
      check($sformatf("%s_w%0d_ch2", tag, k), o2, (k < N) ? m2[k] : 0);
    end
  endtask

  initial begin
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_data_0 = '0;
    bus.load_data_1 = '0;
    bus.load_data_2 = '0;
    bus.start       = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_valid", bus.valid_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_load_err", bus.load_err, 0);
    check("reset_data0", bus.data_out_0, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) begin
      load(k, 32'(k), 32'h100 + 32'(k), 32'h200 + 32'(k));
    end

    run_frame(-1, -1, -1);
    check_frame("f1", 20);
    check("f1_load_err", nerr, 0);

    load(12, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    @(negedge clk);
    check("err_pulse_clear", bus.load_err, 0);
    load(16'hFFFF, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666);

    run_frame(5, 3, -1);
    check_frame("f2", 20);
    check("f2_load_err", nerr, 1);
    repeat (3) @(negedge clk);
    check("f2_no_refire_valid", bus.valid_out, 0);
    check("f2_no_refire_busy", bus.busy, 0);

    run_frame(-1, -1, 7);
    check("rst_nvalid", nvalid, 8);
    check("rst_ndone", ndone, 0);
    check("rst_w7_ch2", (nvalid > 7) ? c2[7] : 32'hxxxx_xxxx, m2[7]);
    run_frame(-1, -1, -1);
    check_frame("f4", 20);

    bus.load_en     = 1'b1;
    bus.load_addr   = '0;
    bus.load_data_0 = 32'hDEAD_BEEF;
    bus.load_data_1 = 32'h100;
    bus.load_data_2 = 32'h200;
    m0[0] = 32'hDEAD_BEEF;
    run_frame(-1, -1, -1);
    check("f5_first_ch0", (nvalid > 0) ? c0[0] : 32'hxxxx_xxxx,
          32'hDEAD_BEEF);
    check("f5_load_err", nerr, 0);
    check_frame("f5", 20);

`ifdef FRAME_STREAM_TX_STALL_EN
    st_a = 3;
    st_a_len = 3;
    st_b = N + 1;
    st_b_len = 2;
    run_frame(-1, -1, -1);
    check_frame("f6", 25);
    st_a = -1;
    st_b = -1;
    stall_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
